// File: rtl/inbuf_cell.sv
// inbuf_cell: receive-side link buffer for one router input port.
// Holds one 64-bit packet per virtual channel, decodes the held header into
// an XY-routed one-hot crossbar request, and releases the packet with the
// active hop field decremented on grant. The link side and crossbar side
// always address opposite VCs, selected by the router-wide polarity bit.
module inbuf_cell (
    input  logic        clk,
    input  logic        reset,
    input  logic        polarity,
    input  logic        si,
    output logic        ri,
    input  logic [63:0] di,
    output logic [4:0]  req,
    input  logic        gnt,
    output logic [63:0] dout,
    output logic [1:0]  full,
    output logic        err
);

    // Request encoding, bit order {PE, S, N, W, E}.
    localparam logic [4:0] REQ_E  = 5'b00001;
    localparam logic [4:0] REQ_W  = 5'b00010;
    localparam logic [4:0] REQ_N  = 5'b00100;
    localparam logic [4:0] REQ_S  = 5'b01000;
    localparam logic [4:0] REQ_PE = 5'b10000;

    logic        link_vc;
    logic        int_vc;
    logic        accept;
    logic [1:0]  full_vec;
    logic [63:0] data_buf [2];
    logic        err_q;

    assign link_vc = polarity;
    assign int_vc  = ~polarity;

    // Ready only depends on registered occupancy, so no path from si/di.
    assign ri     = ~full_vec[link_vc];
    assign accept = si & ~full_vec[link_vc];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            localparam logic VC = 1'(gi);

            logic [63:0] data_q;
            logic        occ_q;
            logic        fill;
            logic        drain;

            // Fill and drain of one VC can never coincide: link and
            // internal phases always address different VCs.
            assign fill  = accept & (link_vc == VC);
            assign drain = gnt & occ_q & (int_vc == VC);

            // Per-VC packet storage and occupancy flag.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    data_q <= '0;
                    occ_q  <= 1'b0;
                end else if (fill) begin
                    data_q <= di;
                    occ_q  <= 1'b1;
                end else if (drain) begin
                    occ_q  <= 1'b0;
                end
            end

            assign data_buf[gi] = data_q;
            assign full_vec[gi] = occ_q;
        end
    endgenerate

    // Sticky protocol error: send into a full VC, or VC tag mismatching phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((si & ~full_vec[link_vc]) ? (di[63] != polarity) : si) begin
            err_q <= 1'b1;
        end
    end

    logic [63:0] pkt;
    logic [3:0]  hop_x;
    logic [3:0]  hop_y;
    logic [4:0]  req_d;
    logic [63:0] dout_d;

    assign pkt   = data_buf[int_vc];
    assign hop_x = pkt[55:52];
    assign hop_y = pkt[51:48];

    // XY routing of the internal-phase VC; X is exhausted before Y, and a
    // zero hop field is never decremented.
    always_comb begin
        req_d  = '0;
        dout_d = '0;
        if (full_vec[int_vc]) begin
            dout_d = pkt;
            if (hop_x != 4'd0) begin
                req_d         = pkt[62] ? REQ_W : REQ_E;
                dout_d[55:52] = hop_x - 4'd1;
            end else if (hop_y != 4'd0) begin
                req_d         = pkt[61] ? REQ_S : REQ_N;
                dout_d[51:48] = hop_y - 4'd1;
            end else begin
                req_d = REQ_PE;
            end
        end
    end

    assign req  = req_d;
    assign dout = dout_d;
    assign full = full_vec;
    assign err  = err_q;

endmodule

// File: tb/tb_inbuf_cell.sv
// Directed testbench for inbuf_cell with hand-computed expectations.
module tb_inbuf_cell;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        si;
    logic        ri;
    logic [63:0] di;
    logic [4:0]  req;
    logic        gnt;
    logic [63:0] dout;
    logic [1:0]  full;
    logic        err;

    int total = 0;
    int bad   = 0;

    inbuf_cell dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .si       (si),
        .ri       (ri),
        .di       (di),
        .req      (req),
        .gnt      (gnt),
        .dout     (dout),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Packets: {vc, dx, dy, rsvd[4:0]} hop_x hop_y payload
    localparam logic [63:0] PKT_X     = 64'h0021_0000_0000_ABCD; // vc0 E, hx=2 hy=1
    localparam logic [63:0] PKT_X_OUT = 64'h0011_0000_0000_ABCD;
    localparam logic [63:0] PKT_Y     = 64'h2003_0000_0000_1234; // vc0 dy=1, hx=0 hy=3
    localparam logic [63:0] PKT_Y_OUT = 64'h2002_0000_0000_1234;
    localparam logic [63:0] PKT_PE    = 64'h9500_5555_AAAA_0F0F; // vc1, hops 0, rsvd 10101
    localparam logic [63:0] PKT_B     = 64'hC010_0000_0000_BEEF; // vc1 W, hx=1
    localparam logic [63:0] PKT_B_OUT = 64'hC000_0000_0000_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pol, input logic s, input logic [63:0] d, input logic g);
        polarity = pol;
        si       = s;
        di       = d;
        gnt      = g;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        step();
        step();
        reset = 1'b1;

        // Reset / idle
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk("rst_full", 64'(full), 64'(2'b00));
        chk("rst_ri",   64'(ri),   64'(1'b1));
        chk("rst_req",  64'(req),  64'(5'b00000));
        chk("rst_dout", dout,      64'h0);
        chk("rst_err",  64'(err),  64'(1'b0));

        // X route: accept on VC0 at polarity 0
        drive(1'b0, 1'b1, PKT_X, 1'b0);
        chk("x_ri", 64'(ri), 64'(1'b1));
        step();
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        chk("x_req",  64'(req),  64'(5'b00001));
        chk("x_dout", dout,      PKT_X_OUT);
        chk("x_full", 64'(full), 64'(2'b01));
        step();

        // Y route: VC0 drained; refill immediately on its next link phase
        drive(1'b0, 1'b1, PKT_Y, 1'b0);
        chk("x_drained", 64'(full), 64'(2'b00));
        chk("idle_req",  64'(req),  64'(5'b00000));
        step();
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        chk("y_req",  64'(req), 64'(5'b01000));
        chk("y_dout", dout,     PKT_Y_OUT);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk("y_drained", 64'(full), 64'(2'b00));
        step();

        // PE route on VC1: packet passes through unchanged
        drive(1'b1, 1'b1, PKT_PE, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk("pe_req",  64'(req), 64'(5'b10000));
        chk("pe_dout", dout,     PKT_PE);
        chk("pe_err",  64'(err), 64'(1'b0));
        step();

        // Backpressure on VC1: fill, then withhold grant for 6 cycles
        drive(1'b1, 1'b1, PKT_B, 1'b0);
        chk("pe_drained", 64'(full), 64'(2'b00));
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1'(k % 2), (k == 3) ? 1'b1 : 1'b0, PKT_X, 1'b0);
            if (k % 2 == 0) begin
                chk("bp_req_int",  64'(req), 64'(5'b00010));
                chk("bp_dout_int", dout,     PKT_B_OUT);
            end else begin
                chk("bp_req_link", 64'(req), 64'(5'b00000));
                chk("bp_ri_link",  64'(ri),  64'(1'b0));
            end
            chk("bp_err", 64'(err), (k >= 4) ? 64'(1'b1) : 64'(1'b0));
            chk("bp_full", 64'(full), 64'(2'b10));
            step();
        end
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk("bp_req_gnt",  64'(req), 64'(5'b00010));
        chk("bp_dout_gnt", dout,     PKT_B_OUT);
        step();
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("bp_drained", 64'(full), 64'(2'b00));

        // Clear sticky error
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(1'b0, 1'b1, PKT_X, 1'b0);
        chk("clr_err", 64'(err), 64'(1'b0));
        step();

        // Concurrency: VC0 granted while VC1 arrives
        drive(1'b1, 1'b1, PKT_B, 1'b1);
        chk("cc_req_vc0", 64'(req), 64'(5'b00001));
        step();
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk("cc_full", 64'(full), 64'(2'b10));
        chk("cc_req",  64'(req),  64'(5'b00010));
        chk("cc_err",  64'(err),  64'(1'b0));
        step();

        // VC mismatch: vc0-tagged packet arrives in VC1 phase
        drive(1'b1, 1'b1, PKT_X, 1'b0);
        chk("mm_pre_full", 64'(full), 64'(2'b00));
        step();
        drive(1'b0, 1'b1, PKT_Y, 1'b0);
        chk("mm_full", 64'(full), 64'(2'b10));
        chk("mm_err",  64'(err),  64'(1'b1));
        chk("mm_req",  64'(req),  64'(5'b00001));
        chk("mm_dout", dout,      PKT_X_OUT);
        step();

        // Reset with both VCs full
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("both_full", 64'(full), 64'(2'b11));
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk("mr_full", 64'(full), 64'(2'b00));
        chk("mr_req",  64'(req),  64'(5'b00000));
        chk("mr_dout", dout,      64'h0);
        chk("mr_err",  64'(err),  64'(1'b0));
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("mr_req1", 64'(req), 64'(5'b00000));
        chk("mr_ri1",  64'(ri),  64'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inbuf_cell.md
# inbuf_cell

Receive-side link buffer of a router input port, the counterpart of the per-port output buffer. It accepts 64-bit packets from a neighbour over the `si`/`ri` handshake, holding one packet per virtual channel (VC0, VC1). It decodes each held packet's header into a one-hot output-port request for the crossbar arbiters. On grant it releases the packet with its hop field decremented. External (link) and internal (crossbar) activity alternate per VC on the router-wide `polarity` bit.

## Interface
- No parameters; data width fixed at 64, two VCs.
- `clk`  in  1  router clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; 0 at a rising edge clears all state
- `polarity`  in  1  router-wide phase bit, toggles every cycle; link VC = `polarity`, internal VC = `~polarity`
- `si`  in  1  neighbour send strobe
- `ri`  out  1  ready to neighbour (combinational)
- `di`  in  64  packet from neighbour
- `req`  out  5  one-hot crossbar request {PE, S, N, W, E} = bits [4:0] in that order
- `gnt`  in  1  grant from the output arbiter for the current `req`
- `dout`  out  64  routed packet to crossbar; zero when `req` is zero
- `full`  out  2  per-VC occupancy, [v] = VC v
- `err`  out  1  sticky protocol-error flag

## Operation
- Packet header: [63] vc; [62] dx (0 = east, 1 = west); [61] dy (0 = north, 1 = south); [60:56] reserved, passed through; [55:52] hop_x; [51:48] hop_y; [47:0] payload.
- Link side, VC e = `polarity`:
  - `ri = ~full[e]`.
  - On `si & ri`, store `di` in buffer e and set `full[e]`.
  - `si` while `ri` = 0: packet dropped, `err` set.
  - Accepted packet with `di[63] != polarity`: stored anyway, `err` set.
- Internal side, VC i = `~polarity`: when `full[i]`, `req` is driven from buffer i's header (XY routing):
  - hop_x != 0: `req` = E (dx = 0) or W (dx = 1); `dout` has hop_x − 1.
  - else hop_y != 0: `req` = N (dy = 0) or S (dy = 1); `dout` has hop_y − 1.
  - else: `req` = PE; `dout` equals the stored packet unchanged.
  - All other `dout` bits equal the stored packet.
- When `full[i]` = 0: `req` = 0, `dout` = 0.
- `gnt & full[i]` at a rising edge clears `full[i]`. `gnt` with `req` = 0 is ignored.
- Hop decrement is 4-bit and never wraps: a zero field is never decremented.
- Link and internal sides always address different VCs, so a fill and a drain in the same cycle are independent and both take effect.
- `err` clears only on reset.

## Timing
- Reset (`reset` = 0 at an edge) gives: `full` = 2'b00, buffers = 0, `err` = 0. Outputs then show `ri` = 1, `req` = 0, `dout` = 0.
- Reset mid-operation discards both buffers without any `req`.
- `ri`, `req` and `dout` are combinational from registered state and `polarity`; no combinational path from `si`/`di` to any output.
- Latency: a packet accepted at edge N (polarity p) raises `req` in cycle N+1 (polarity ~p). This is the minimum, one cycle.
- An ungranted packet re-requests every second cycle, whenever its VC is internal. It holds `ri` low on that VC's link phases.
- Back-to-back: a VC granted in cycle k can be refilled at edge k+1 (its next link phase). The sustained rate is one packet per VC per two cycles.
- `gnt` is sampled only at the edge ending the internal-phase cycle of the requesting VC.

## Test plan
- Reset / idle: `reset` = 0 for 2 edges, then 1 → `full` = 0, `ri` = 1, `req` = 0, `dout` = 0, `err` = 0.
- X route:
  - Stimulus: polarity = 0, si = 1, di = 64'h0_0_2_1_0000_0000_ABCD with vc0, dx = 0, hop_x = 2, hop_y = 1.
  - Cycle N+1: `req` = 5'b00001 and `dout` hop_x = 1, hop_y = 1.
  - `gnt` = 1 at that edge → `full[0]` = 0.
- Y and PE routes:
  - hop_x = 0, hop_y = 3, dy = 1 → `req` = 5'b01000, hop_y out = 2.
  - hop_x = hop_y = 0 → `req` = 5'b10000, `dout` == stored packet.
- Backpressure: fill VC1 and withhold `gnt` for 6 cycles → `req` pulses every other cycle, and `ri` = 0 whenever polarity = 1. A `si` pulse during that time sets `err` and leaves the buffer unchanged.
- Concurrency: VC0 full and granted in the same cycle that a VC1 packet arrives → both take effect; the next cycle `full` = 2'b10.
- VC mismatch and reset mid-flight:
  - polarity = 1 with di[63] = 0 → packet stored in VC1, `err` = 1.
  - Assert `reset` while both VCs are full → next cycle `full` = 0, `req` = 0, `err` = 0.
